// File: rtl/wb_stage.sv
// Write-back stage: MEM/WB pipeline register, write-back mux, redirect generation
// and a squash window that suppresses the in-flight slots behind a taken redirect.
module wb_stage #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_W   = 6,
    parameter int unsigned SHADOW = 2
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Stall,
    input  logic              valid_in,
    input  logic [DATA_W-1:0] ALU_result,
    input  logic [DATA_W-1:0] read_data,
    input  logic              Zero,
    input  logic              Neg,
    input  logic              MemtoReg_in,
    input  logic              RegWrite_in,
    input  logic              Jump_in,
    input  logic              JumpM_in,
    input  logic              BrZ_in,
    input  logic              BrN_in,
    input  logic [RD_W-1:0]   rd_in,
    output logic [DATA_W-1:0] wb_data,
    output logic [RD_W-1:0]   wb_rd,
    output logic              wb_en,
    output logic              redirect,
    output logic [DATA_W-1:0] redirect_pc,
    output logic [15:0]       retire_count
);

    localparam int unsigned CNT_W = 3;
    localparam int unsigned RET_W = 16;

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SHADOW = 1'b1
    } state_t;

    logic              r_valid;
    logic              r_memtoreg;
    logic              r_regwrite;
    logic              r_jump;
    logic              r_jumpm;
    logic              r_brz;
    logic              r_brn;
    logic              r_zero;
    logic              r_neg;
    logic [DATA_W-1:0] r_alu;
    logic [DATA_W-1:0] r_rdata;
    logic [RD_W-1:0]   r_rd;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [CNT_W-1:0]  r_shadow_cnt;
    logic [CNT_W-1:0]  w_shadow_cnt_nxt;
    logic [RET_W-1:0]  r_retire;

    logic              w_taken;
    logic              w_retire;
    logic              w_redirect;

    // MEM/WB pipeline register; frozen while stalled
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_valid    <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_jump     <= 1'b0;
            r_jumpm    <= 1'b0;
            r_brz      <= 1'b0;
            r_brn      <= 1'b0;
            r_zero     <= 1'b0;
            r_neg      <= 1'b0;
            r_alu      <= '0;
            r_rdata    <= '0;
            r_rd       <= '0;
        end else if (!Stall) begin
            r_valid    <= valid_in;
            r_memtoreg <= MemtoReg_in;
            r_regwrite <= RegWrite_in;
            r_jump     <= Jump_in;
            r_jumpm    <= JumpM_in;
            r_brz      <= BrZ_in;
            r_brn      <= BrN_in;
            r_zero     <= Zero;
            r_neg      <= Neg;
            r_alu      <= ALU_result;
            r_rdata    <= read_data;
            r_rd       <= rd_in;
        end
    end

    assign w_taken = r_jump | r_jumpm | (r_brz & r_zero) | (r_brn & r_neg);

    // State and squash counter register
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state      <= ST_RUN;
            r_shadow_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_shadow_cnt <= w_shadow_cnt_nxt;
        end
    end

    // Next-state: a non-stalled valid slot either retires (RUN) or is squashed (SHADOW)
    always_comb begin
        w_state_nxt      = r_state;
        w_shadow_cnt_nxt = r_shadow_cnt;
        w_retire         = 1'b0;
        w_redirect       = 1'b0;
        if (!Stall && r_valid) begin
            case (r_state)
                ST_RUN: begin
                    w_retire = 1'b1;
                    if (w_taken) begin
                        w_redirect       = 1'b1;
                        w_state_nxt      = ST_SHADOW;
                        w_shadow_cnt_nxt = CNT_W'(SHADOW);
                    end
                end
                ST_SHADOW: begin
                    w_shadow_cnt_nxt = r_shadow_cnt - CNT_W'(1);
                    if (r_shadow_cnt == CNT_W'(1)) begin
                        w_state_nxt = ST_RUN;
                    end
                end
                default: begin
                    w_state_nxt      = ST_RUN;
                    w_shadow_cnt_nxt = '0;
                end
            endcase
        end
    end

    // Saturating retire counter
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_retire <= '0;
        end else if (w_retire && (r_retire != {RET_W{1'b1}})) begin
            r_retire <= r_retire + RET_W'(1);
        end
    end

    // JumpM target comes from memory and overrides a simultaneous register jump
    assign redirect_pc  = r_jumpm ? r_rdata : r_alu;
    assign wb_data      = r_memtoreg ? r_rdata : r_alu;
    assign wb_rd        = r_rd;
    assign wb_en        = w_retire & r_regwrite;
    assign redirect     = w_redirect;
    assign retire_count = r_retire;

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameters: DATA_W, default 32, datapath width; RD_W, default 6, destination register index width; SHADOW, default 2, number of in-flight instructions squashed after a redirect (legal 1..7).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 Clk  in  1  rising-edge clock.
REQ-004 Rst  in  1  synchronous active-high reset.
REQ-005 Stall  in  1  hold the pipeline register this cycle.
REQ-006 valid_in  in  1  upstream EX_M slot holds a real instruction.
REQ-007 ALU_result  in  DATA_W  EX_M ALU output; also the register jump target.
REQ-008 read_data  in  DATA_W  EX_M memory read data; also the memory jump target.
REQ-009 Zero, Neg  in  1 each  EX_M ALU flags.
REQ-010 MemtoReg_in, RegWrite_in, Jump_in, JumpM_in, BrZ_in, BrN_in  in  1 each  control bits from EX_M.
REQ-011 rd_in  in  RD_W  destination register index.
REQ-012 wb_data  out  DATA_W  write-back data to the register file.
REQ-013 wb_rd  out  RD_W  write-back register index.
REQ-014 wb_en  out  1  register-file write strobe.
REQ-015 redirect  out  1  one-cycle PC redirect pulse.
REQ-016 redirect_pc  out  DATA_W  redirect target; valid while redirect=1.
REQ-017 retire_count  out  16  count of retired (non-squashed) instructions.

Function
REQ-018 Latency: one cycle; the MEM/WB register captures inputs on the rising Clk edge when Stall=0; outputs are driven from the registered copy.
REQ-019 While Stall=1, the register, FSM state, shadow counter and retire_count hold; wb_en and redirect are 0 during stalled cycles.
REQ-020 wb_data is read_data when the registered MemtoReg is 1, else ALU_result.
REQ-021 wb_en = registered valid AND registered RegWrite AND state=RUN AND not stalled; wb_rd is the registered rd_in.
REQ-022 Redirect condition on the registered slot: Jump, or JumpM, or (BrZ AND Zero), or (BrN AND Neg); it is qualified by valid and state=RUN.
REQ-023 redirect_pc priority: JumpM selects read_data; otherwise ALU_result. If Jump and JumpM are both 1, JumpM wins.
REQ-024 FSM states: RUN and SHADOW.
REQ-025 RUN -> SHADOW on a redirect; the shadow counter loads SHADOW.
REQ-026 In SHADOW, each captured valid slot is squashed: no wb_en, no redirect, no retire. The counter decrements per squashed valid slot. SHADOW -> RUN when a decrement reaches 0.
REQ-027 Invalid slots (valid_in=0) in SHADOW do not decrement the counter.
REQ-028 A redirecting instruction is itself retired and may also write back (e.g. jump-and-link style RegWrite=1).
REQ-029 retire_count increments by 1 for each non-squashed valid slot and saturates at 16'hFFFF, with no wrap.

Reset
REQ-030 Rst=1 at a rising edge takes priority over Stall and clears the valid bit, all registered controls, wb_data, wb_rd and redirect_pc to 0, and state to RUN, shadow counter to 0, retire_count to 0.
REQ-031 Outputs wb_en=0, redirect=0, retire_count=0 in the cycle after reset; reset in SHADOW abandons the squash window.

Verification
REQ-032 Write-back select: ALU_result=0x1C, read_data=0xAA, RegWrite=1, rd_in=5, MemtoReg=0 -> next cycle wb_en=1, wb_rd=5, wb_data=0x1C; repeat with MemtoReg=1 -> wb_data=0xAA.
REQ-033 Memory jump: JumpM=1, read_data=0x40 -> redirect=1 for one cycle with redirect_pc=0x40; the next 2 valid slots (RegWrite=1) give wb_en=0, and the third gives wb_en=1. Across these slots retire_count advances by 2 (the jump and the third), not 4.
REQ-034 Branch flags: BrZ=1, Zero=0 -> no redirect; BrN=1, Neg=1, ALU_result=0x10 -> redirect_pc=0x10.
REQ-035 Stall and gaps: Stall=1 for 3 cycles with a valid RegWrite slot -> wb_en=0 throughout and the slot writes once after release. In SHADOW, inserting valid_in=0 bubbles extends the window until 2 valid slots have been squashed.
REQ-036 Reset mid-SHADOW: Rst after redirect -> the next valid RegWrite slot writes (wb_en=1) and retire_count restarts at 1; preload near 0xFFFF -> saturates at 0xFFFF.
